// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational ALU between two requesters. The block
// picks one port per cycle round-robin, drives the ALU with that port's
// operands, and captures the ALU result into the port's one-deep response
// buffer. It also counts accepted requests per port.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   req_valid    [2]          request valid, bit i = port i
//   req_ready    [2]          request ready (at most one bit set)
//   req_a/req_b  [2*WIDTH]    operands, port i at [i*WIDTH +: WIDTH]
//   req_ctrl     [2*CTRL_W]   ALU control code, same packing
//   resp_valid   [2]          response valid
//   resp_ready   [2]          response ready
//   resp_result  [2*WIDTH]    registered ALU result per port
//   resp_err     [2]          registered op used the all-ones control code
//   alu_a/alu_b  [WIDTH]      operands to the shared ALU
//   alu_control  [CTRL_W]     control code to the shared ALU
//   alu_result   [WIDTH]      combinational result from the shared ALU
//   grant_cnt    [2*CNT_W]    per-port accepted-request count (wraps)
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*WIDTH-1:0]  req_a,
    input  logic [2*WIDTH-1:0]  req_b,
    input  logic [2*CTRL_W-1:0] req_ctrl,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic [2*WIDTH-1:0]  resp_result,
    output logic [1:0]          resp_err,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [CTRL_W-1:0]   alu_control,
    input  logic [WIDTH-1:0]    alu_result,
    output logic [2*CNT_W-1:0]  grant_cnt
);

    // Per-port state
    logic              r_resp_valid [2];
    logic              r_resp_err   [2];
    logic [WIDTH-1:0]  r_result     [2];
    logic [CNT_W-1:0]  r_cnt        [2];
    // Port favoured when both ports are candidates
    logic              r_ptr;

    // Unpacked views of the request buses
    logic [WIDTH-1:0]  w_a    [2];
    logic [WIDTH-1:0]  w_b    [2];
    logic [CTRL_W-1:0] w_ctrl [2];

    logic [1:0] w_slot_free;
    logic [1:0] w_cand;
    logic       w_contested;
    logic       w_grant;
    logic       w_winner;
    logic [1:0] w_accept;
    logic       w_illegal;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port_wires
            assign w_a[gi]    = req_a[gi*WIDTH +: WIDTH];
            assign w_b[gi]    = req_b[gi*WIDTH +: WIDTH];
            assign w_ctrl[gi] = req_ctrl[gi*CTRL_W +: CTRL_W];
            // A slot is free if empty or being drained this cycle, so a drain
            // and a new accept can share an edge.
            assign w_slot_free[gi] = !r_resp_valid[gi] || resp_ready[gi];
            // Nothing is granted while reset is asserted.
            assign w_cand[gi] = req_valid[gi] && w_slot_free[gi] && !rst;
        end
    endgenerate

    assign w_contested = w_cand[0] && w_cand[1];
    assign w_grant     = w_cand[0] || w_cand[1];

    // With a single candidate, port 1 wins exactly when it is the candidate.
    always_comb begin
        w_winner = w_cand[1];
        if (w_contested) begin
            w_winner = r_ptr;
        end
    end

    always_comb begin
        w_accept = 2'b00;
        if (w_grant) begin
            w_accept[w_winner] = 1'b1;
        end
    end

    assign req_ready = w_accept;

    // Idle ALU input is all zeros (control 0 = add, 0+0).
    assign alu_a       = w_grant ? w_a[w_winner]    : '0;
    assign alu_b       = w_grant ? w_b[w_winner]    : '0;
    assign alu_control = w_grant ? w_ctrl[w_winner] : '0;

    // The all-ones control code is the only one the arbiter interprets.
    assign w_illegal = (alu_control == {CTRL_W{1'b1}});

    // After a contested grant, favour the other port next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_contested) begin
            r_ptr <= !w_winner;
        end
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port_regs
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_resp_valid[gi] <= 1'b0;
                    r_resp_err[gi]   <= 1'b0;
                    r_result[gi]     <= '0;
                    r_cnt[gi]        <= '0;
                end else if (w_accept[gi]) begin
                    r_resp_valid[gi] <= 1'b1;
                    r_resp_err[gi]   <= w_illegal;
                    r_result[gi]     <= alu_result;
                    r_cnt[gi]        <= r_cnt[gi] + 1'b1;
                end else if (resp_ready[gi]) begin
                    r_resp_valid[gi] <= 1'b0;
                end
            end

            assign resp_valid[gi]                 = r_resp_valid[gi];
            assign resp_err[gi]                   = r_resp_err[gi];
            assign resp_result[gi*WIDTH +: WIDTH] = r_result[gi];
            assign grant_cnt[gi*CNT_W +: CNT_W]   = r_cnt[gi];
        end
    endgenerate

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Drives alu_share_arbiter with directed scenarios followed by random traffic,
// and compares every cycle against a transaction-level model of the arbiter.
// The shared ALU itself is modelled here as a simple combinational function.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*WIDTH-1:0]  req_a;
    logic [2*WIDTH-1:0]  req_b;
    logic [2*CTRL_W-1:0] req_ctrl;
    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready;
    logic [2*WIDTH-1:0]  resp_result;
    logic [1:0]          resp_err;
    logic [WIDTH-1:0]    alu_a;
    logic [WIDTH-1:0]    alu_b;
    logic [CTRL_W-1:0]   alu_control;
    logic [WIDTH-1:0]    alu_result;
    logic [2*CNT_W-1:0]  grant_cnt;

    int n_checks = 0;
    int n_errors = 0;

    alu_share_arbiter #(
        .WIDTH (WIDTH),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result),
        .resp_err   (resp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_control(alu_control),
        .alu_result (alu_result),
        .grant_cnt  (grant_cnt)
    );

    always #5 clk = ~clk;

    // Shared ALU model (external to the arbiter)
    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [CTRL_W-1:0] c);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return a >> b[4:0];
            4'd4:    return $unsigned($signed(a) >>> b[4:0]);
            4'd5:    return {31'd0, $signed(a) < $signed(b)};
            4'd6:    return {31'd0, a < b};
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return a ^ b;
            4'd15:   return '0;
            default: return a ^ ~b;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_control);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what each port's response buffer holds, the counters,
    // and which port won the last contested round.
    bit               m_known = 0;
    bit               m_valid   [2];
    bit               m_err     [2];
    logic [WIDTH-1:0] m_result  [2];
    int               m_count   [2];
    int               m_last_contested_winner;
    logic [1:0]       s_ready;

    task automatic cycle(input bit r, input logic [1:0] rv, input logic [1:0] rr,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1);
        logic [31:0] ea [2];
        logic [31:0] eb [2];
        logic [3:0]  ec [2];
        bit          cand [2];
        int          win;
        logic [1:0]  exp_ready;
        ea[0] = a0; eb[0] = b0; ec[0] = c0;
        ea[1] = a1; eb[1] = b1; ec[1] = c1;

        rst        = r;
        req_valid  = rv;
        resp_ready = rr;
        req_a      = {a1, a0};
        req_b      = {b1, b0};
        req_ctrl   = {c1, c0};
        #4;

        // A port may take a new request if its buffer is empty or draining.
        for (int i = 0; i < 2; i++)
            cand[i] = !r && rv[i] && (!m_valid[i] || rr[i]);
        win = -1;
        if (cand[0] && cand[1]) win = 1 - m_last_contested_winner;
        else if (cand[0])       win = 0;
        else if (cand[1])       win = 1;
        exp_ready = 2'b00;
        if (win >= 0) exp_ready[win] = 1'b1;

        s_ready = req_ready;
        check("req_ready", {62'd0, req_ready}, {62'd0, exp_ready});
        check("alu_a", {32'd0, alu_a}, {32'd0, (win >= 0) ? ea[win] : 32'd0});
        check("alu_b", {32'd0, alu_b}, {32'd0, (win >= 0) ? eb[win] : 32'd0});
        check("alu_ctrl", {60'd0, alu_control}, {60'd0, (win >= 0) ? ec[win] : 4'd0});
        if (m_known) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("resp_valid%0d", i), {63'd0, resp_valid[i]}, {63'd0, m_valid[i]});
                check($sformatf("grant_cnt%0d", i), {60'd0, grant_cnt[i*CNT_W +: CNT_W]},
                      64'(m_count[i] % (1 << CNT_W)));
                if (m_valid[i]) begin
                    check($sformatf("resp_result%0d", i), {32'd0, resp_result[i*WIDTH +: WIDTH]},
                          {32'd0, m_result[i]});
                    check($sformatf("resp_err%0d", i), {63'd0, resp_err[i]}, {63'd0, m_err[i]});
                end
            end
        end

        if (win >= 0)
            $display("t=%0t grant port %0d ctrl=%h a=%h b=%h", $time, win, ec[win], ea[win], eb[win]);

        @(posedge clk);
        #1;

        if (r) begin
            m_known = 1;
            m_last_contested_winner = 1;
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 0; m_err[i] = 0; m_result[i] = '0; m_count[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (win == i) begin
                    m_valid[i]  = 1;
                    m_result[i] = alu_fn(ea[i], eb[i], ec[i]);
                    m_err[i]    = (ec[i] == 4'hF);
                    m_count[i]  = m_count[i] + 1;
                end else if (rr[i]) begin
                    m_valid[i] = 0;
                end
            end
            if (cand[0] && cand[1]) m_last_contested_winner = win;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; resp_ready = '0;
        req_a = '0; req_b = '0; req_ctrl = '0;
        m_last_contested_winner = 1;
        @(posedge clk);
        #1;

        // Reset, then a single add on port 0
        cycle(1, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);
        check("rst_valid", {62'd0, resp_valid}, 64'd0);
        check("rst_cnt", {56'd0, grant_cnt}, 64'd0);
        cycle(0, 2'b01, 2'b11, 5, 3, 4'h0, 0, 0, 0);
        check("add_ready", {62'd0, s_ready}, 64'd1);
        check("add_valid", {63'd0, resp_valid[0]}, 64'd1);
        check("add_result", {32'd0, resp_result[31:0]}, 64'd8);
        check("add_cnt", {60'd0, grant_cnt[3:0]}, 64'd1);

        // Continuous contention: grants alternate
        cycle(1, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            cycle(0, 2'b11, 2'b11, 10, 4, 4'h1, 1, 4, 4'h2);
            check("alt_order", {62'd0, s_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
        end
        check("alt_cnt", {56'd0, grant_cnt}, 64'h44);
        check("alt_res0", {32'd0, resp_result[31:0]}, 64'd6);
        check("alt_res1", {32'd0, resp_result[63:32]}, 64'd16);

        // Backpressure on port 1
        cycle(0, 2'b10, 2'b11, 0, 0, 0, 32'hF0, 32'h3C, 4'h9);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 2'b11, 2'b01, k, 1, 4'h0, 7, 7, 4'h0);
            check("bp_ready", {62'd0, s_ready}, 64'd1);
            check("bp_hold", {32'd0, resp_result[63:32]}, 64'h30);
        end
        cycle(0, 2'b10, 2'b11, 0, 0, 0, 3, 4, 4'h0);
        check("bp_release", {62'd0, s_ready}, 64'd2);

        // Illegal control code
        cycle(0, 2'b01, 2'b11, 32'h1234, 32'h99, 4'hF, 0, 0, 0);
        check("ill_err", {63'd0, resp_err[0]}, 64'd1);
        check("ill_res", {32'd0, resp_result[31:0]}, 64'd0);
        cycle(0, 2'b01, 2'b11, 2, 2, 4'h0, 0, 0, 0);
        check("ill_clear", {63'd0, resp_err[0]}, 64'd0);

        // Counter wrap at 2^CNT_W
        cycle(1, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 17; k++)
            cycle(0, 2'b01, 2'b01, k, 1, 4'h0, 0, 0, 0);
        check("wrap_cnt", {60'd0, grant_cnt[3:0]}, 64'd1);

        // Reset in the middle of traffic
        cycle(0, 2'b01, 2'b00, 1, 1, 4'h0, 0, 0, 0);
        cycle(1, 2'b11, 2'b00, 1, 1, 4'h0, 2, 2, 4'h0);
        check("mid_rst_ready", {62'd0, s_ready}, 64'd0);
        check("mid_rst_valid", {62'd0, resp_valid}, 64'd0);
        check("mid_rst_cnt", {56'd0, grant_cnt}, 64'd0);
        cycle(0, 2'b11, 2'b11, 1, 1, 4'h0, 2, 2, 4'h0);
        check("mid_rst_first", {62'd0, s_ready}, 64'd1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 49) == 0),
                  2'($urandom), 2'($urandom),
                  $urandom, $urandom, 4'($urandom),
                  $urandom, $urandom, 4'($urandom));
        end
        cycle(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
